// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared encodings for the program-counter controller.
//   cmp_e   : compare code produced by the branch comparator (EQ/LT/GT).
//   br_op_e : conditional-branch opcode driven by the decoder.
//   branch_offset() : sign-extended word offset converted to a byte offset.
//   is_branch()     : true for every defined conditional-branch opcode.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_e;

    // Code 3'd7 is unassigned and behaves exactly like BR_NONE.
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BGT  = 3'd5,
        BR_BLE  = 3'd6
    } br_op_e;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic is_branch(input logic [2:0] op);
        return (op >= BR_BEQ) && (op <= BR_BLE);
    endfunction

endpackage

// File: rtl/pc_ctrl_br_decide.sv
// br_decide: decides whether a conditional branch is taken.
//   branch [1:0] : compare code (cmp_e) from the branch comparator
//   br_op  [2:0] : branch opcode (br_op_e); undefined codes never take
//   taken        : 1 when the branch condition holds
module br_decide
    import pc_ctrl_pkg::*;
(
    input  logic [1:0] branch,
    input  logic [2:0] br_op,
    output logic       taken
);

    logic is_eq;
    logic is_lt;
    logic is_gt;

    assign is_eq = (branch == CMP_EQ);
    assign is_lt = (branch == CMP_LT);
    assign is_gt = (branch == CMP_GT);

    // NOTE: a default assignment ahead of the case keeps this purely
    // combinational; any path that skipped 'taken' would infer a latch.
    always_comb begin
        taken = 1'b0;
        case (br_op)
            BR_BEQ:  taken = is_eq;
            BR_BNE:  taken = !is_eq;
            BR_BLT:  taken = is_lt;
            BR_BGE:  taken = is_gt || is_eq;
            BR_BGT:  taken = is_gt;
            BR_BLE:  taken = is_lt || is_eq;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter register with branch/jump/jr target selection.
//   clk, rst      : single clock, asynchronous active-high reset
//   stall         : freezes pc, redirect, align_err (and counters)
//   branch, br_op : compare code and branch opcode, decoded by br_decide
//   jump, imm26   : J-type jump and its word index
//   jr, rs_val    : register-indirect jump and its byte target
//   imm16         : branch offset in words
//   pc            : current PC register
//   pc_plus4      : combinational pc+4 (link value)
//   redirect      : 1 for the cycle after a non-sequential PC load
//   align_err     : sticky flag, set by a misaligned jr target
// Optional feature, macro BRANCH_STATS_EN: adds br_cnt (branches seen)
// and taken_cnt (branches taken and selected), both wrapping 32-bit.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  branch,
    input  logic [2:0]  br_op,
    input  logic        jump,
    input  logic        jr,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        align_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt
`endif
);

    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;
    logic        align_err_q, align_err_d;

    logic        taken;
    logic [31:0] br_target;
    logic [31:0] j_target;

    br_decide u_br_decide (
        .branch (branch),
        .br_op  (br_op),
        .taken  (taken)
    );

    // Adders wrap naturally modulo 2^32, covering pc wrap and branch wrap.
    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + branch_offset(imm16);
    assign j_target  = {pc_plus4[31:28], imm26, 2'b00};

    always_comb begin
        pc_d        = pc_q;
        redirect_d  = redirect_q;
        align_err_d = align_err_q;
        if (!stall) begin
            pc_d       = pc_plus4;
            redirect_d = 1'b0;
            if (jr) begin
                // A misaligned jr still wins priority but degrades to a
                // sequential step, so neither jump nor branch is taken.
                if (rs_val[1:0] != 2'b00) begin
                    align_err_d = 1'b1;
                end else begin
                    pc_d       = rs_val;
                    redirect_d = 1'b1;
                end
            end else if (jump) begin
                pc_d       = j_target;
                redirect_d = 1'b1;
            end else if (taken) begin
                pc_d       = br_target;
                redirect_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            redirect_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            align_err_q <= align_err_d;
        end
    end

    assign pc        = pc_q;
    assign redirect  = redirect_q;
    assign align_err = align_err_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (!stall && is_branch(br_op)) begin
            br_cnt_d = br_cnt_q + 32'd1;
            // Counted only when the branch actually steers the PC.
            if (taken && !jr && !jump) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q    <= 32'd0;
            taken_cnt_q <= 32'd0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

endmodule
